// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package hazard_pkg;

    // Shadow destination field width; the top zero-extends REG_BITS-wide
    // specifiers into it, so any REG_BITS up to this value is supported.
    localparam int SHADOW_DEST_BITS = 8;

    // EX-stage operand-mux select codes (2'b11 is never driven).
    localparam logic [1:0] FWD_REG = 2'b00;  // register-file data
    localparam logic [1:0] FWD_WB  = 2'b01;  // WB write data
    localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hazard_state_t;

    typedef struct packed {
        logic [SHADOW_DEST_BITS-1:0] dest;
        logic                        reg_write;
        logic                        mem_read;
    } shadow_entry_t;

    localparam shadow_entry_t SHADOW_BUBBLE = '0;

    // Select for one source operand given the shadow EX and MEM entries.
    // EX wins over MEM because it holds the younger write to that register.
    function automatic logic [1:0] fwd_pick(
        input logic                        used,
        input logic [SHADOW_DEST_BITS-1:0] src,
        input shadow_entry_t               ex,
        input shadow_entry_t               mem
    );
        fwd_pick = FWD_REG;
        if (used && (src != '0)) begin
            if (ex.reg_write && (ex.dest == src)) begin
                fwd_pick = FWD_MEM;
            end else if (mem.reg_write && (mem.dest == src)) begin
                fwd_pick = FWD_WB;
            end
        end
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline entry {dest, reg_write, mem_read}; loads d or a bubble.
// Latency: 1 cycle (registered on the rising clock edge).
// Backpressure: none; bubble forces an all-zero entry, reset likewise.
// Ports: clock, reset (sync, active-high), bubble, d (next entry), q (entry).
module hazard_shadow_stage
    import hazard_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          bubble,
    input  shadow_entry_t d,
    output shadow_entry_t q
);

    always_ff @(posedge clock) begin
        if (reset || bubble) begin
            q <= SHADOW_BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller for a 5-stage MIPS pipeline: forwarding selects, load-use stall, branch flush.
// Latency: fwdA/fwdB registered (ID decision visible in EX next cycle); stall/flush outputs combinational.
// Backpressure: load-use holds PC and IF/ID for exactly one cycle; a taken branch overrides the stall.
// Ports: clock, reset (sync, active-high); ID-stage fields idRs/idRt/idUsesRs/idUsesRt/idDest/
//        idRegWrite/idMemRead; branchTaken; outputs fwdA/fwdB, pcWrite/ifIdWrite,
//        ifIdFlush/idExFlush, and saturating stallCount/flushCount.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REG_BITS-1:0] idRs,
    input  logic [REG_BITS-1:0] idRt,
    input  logic                idUsesRs,
    input  logic                idUsesRt,
    input  logic [REG_BITS-1:0] idDest,
    input  logic                idRegWrite,
    input  logic                idMemRead,
    input  logic                branchTaken,
    output logic [1:0]          fwdA,
    output logic [1:0]          fwdB,
    output logic                pcWrite,
    output logic                ifIdWrite,
    output logic                ifIdFlush,
    output logic                idExFlush,
    output logic [CNT_BITS-1:0] stallCount,
    output logic [CNT_BITS-1:0] flushCount
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [SHADOW_DEST_BITS-1:0] rs, rt;
    shadow_entry_t               id_entry, ex_q, mem_q, wb_q;
    hazard_state_t               state_q, state_d;

    logic ex_hits_rs, ex_hits_rt;
    logic load_use, branch, stall, squash;
    logic [1:0] fwd_a_d, fwd_b_d;

    assign rs = SHADOW_DEST_BITS'(idRs);
    assign rt = SHADOW_DEST_BITS'(idRt);

    assign id_entry.dest      = SHADOW_DEST_BITS'(idDest);
    assign id_entry.reg_write = idRegWrite;
    assign id_entry.mem_read  = idMemRead;

    // Shadow pipeline EX -> MEM -> WB. Only EX ever takes a bubble; older
    // entries keep draining while the front end is held or flushed.
    hazard_shadow_stage u_ex (
        .clock (clock),
        .reset (reset),
        .bubble(squash),
        .d     (id_entry),
        .q     (ex_q)
    );

    hazard_shadow_stage u_mem (
        .clock (clock),
        .reset (reset),
        .bubble(1'b0),
        .d     (ex_q),
        .q     (mem_q)
    );

    hazard_shadow_stage u_wb (
        .clock (clock),
        .reset (reset),
        .bubble(1'b0),
        .d     (mem_q),
        .q     (wb_q)
    );

    // WB is tracked for completeness of the shadow pipeline; the WB-data
    // path is selected from the MEM entry one cycle ahead, so nothing reads it.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    // Register 0 never matches: the explicit src != 0 terms also keep a load
    // to $0 from ever stalling.
    assign ex_hits_rs = idUsesRs && (rs != '0) && (ex_q.dest == rs);
    assign ex_hits_rt = idUsesRt && (rt != '0) && (ex_q.dest == rt);

    // Reset suppresses every hazard so the front end runs freely.
    assign load_use = !reset && ex_q.mem_read && ex_q.reg_write && (ex_q.dest != '0)
                      && (ex_hits_rs || ex_hits_rt);
    assign branch   = !reset && branchTaken;
    // A taken branch makes the stalled ID instruction wrong-path, so it wins.
    assign stall    = load_use && !branch;
    assign squash   = load_use || branch;

    assign fwd_a_d = fwd_pick(idUsesRs, rs, ex_q, mem_q);
    assign fwd_b_d = fwd_pick(idUsesRt, rt, ex_q, mem_q);

    always_comb begin
        state_d   = state_q;
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        ifIdFlush = 1'b0;
        idExFlush = 1'b0;

        case (state_q)
            RUN:     if (stall) state_d = STALL;
            // The bubble inserted on entry means EX cannot hold a load here.
            STALL:   state_d = RUN;
            default: state_d = RUN;
        endcase

        if (stall) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
        end
        if (branch) begin
            ifIdFlush = 1'b1;
        end
        if (squash) begin
            idExFlush = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            fwdA       <= FWD_REG;
            fwdB       <= FWD_REG;
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            state_q <= state_d;
            // A squashed slot enters EX as a bubble, which needs no operands.
            fwdA    <= squash ? FWD_REG : fwd_a_d;
            fwdB    <= squash ? FWD_REG : fwd_b_d;
            if (stall && (stallCount != CNT_MAX)) begin
                stallCount <= stallCount + CNT_BITS'(1);
            end
            if (branch && (flushCount != CNT_MAX)) begin
                flushCount <= flushCount + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    localparam int RB   = 5;
    localparam int CB   = 4;   // narrow counters so saturation is reachable quickly
    localparam int CMAX = (1 << CB) - 1;

    logic          clock;
    logic          reset;
    logic [RB-1:0] idRs, idRt, idDest;
    logic          idUsesRs, idUsesRt, idRegWrite, idMemRead, branchTaken;
    logic [1:0]    fwdA, fwdB;
    logic          pcWrite, ifIdWrite, ifIdFlush, idExFlush;
    logic [CB-1:0] stallCount, flushCount;

    hazard_forward_unit #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
        .clock      (clock),
        .reset      (reset),
        .idRs       (idRs),
        .idRt       (idRt),
        .idUsesRs   (idUsesRs),
        .idUsesRt   (idUsesRt),
        .idDest     (idDest),
        .idRegWrite (idRegWrite),
        .idMemRead  (idMemRead),
        .branchTaken(branchTaken),
        .fwdA       (fwdA),
        .fwdB       (fwdB),
        .pcWrite    (pcWrite),
        .ifIdWrite  (ifIdWrite),
        .ifIdFlush  (ifIdFlush),
        .idExFlush  (idExFlush),
        .stallCount (stallCount),
        .flushCount (flushCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // History of what entered EX each cycle, most recent first:
    // [0] is now in EX, [1] is now in MEM.
    typedef struct {
        int dest;
        bit rw;
        bit mr;
    } instr_t;

    instr_t issued[$];
    instr_t bubble_i = '{dest: 0, rw: 1'b0, mr: 1'b0};
    int     m_fa, m_fb, m_sc, m_fc;
    bit     model_valid = 1'b0;
    bit     prev_low    = 1'b0;

    function automatic int sel(input bit used, input int s);
        if (!used || s == 0) return 0;
        if (issued[0].rw && issued[0].dest == s) return 2;
        if (issued[1].rw && issued[1].dest == s) return 1;
        return 0;
    endfunction

    function automatic bit lu();
        int d;
        d = issued[0].dest;
        return issued[0].mr && issued[0].rw && d != 0 &&
               ((idUsesRs && int'(idRs) == d) || (idUsesRt && int'(idRt) == d));
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            issued = {};
            issued.push_back(bubble_i);
            issued.push_back(bubble_i);
            issued.push_back(bubble_i);
            m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            bit l, sq;
            int fa, fb;
            l  = lu();
            sq = l || branchTaken;
            fa = sq ? 0 : sel(idUsesRs, int'(idRs));
            fb = sq ? 0 : sel(idUsesRt, int'(idRt));
            if (l && !branchTaken && m_sc < CMAX) m_sc++;
            if (branchTaken && m_fc < CMAX) m_fc++;
            if (sq) issued.push_front(bubble_i);
            else    issued.push_front('{dest: int'(idDest), rw: idRegWrite, mr: idMemRead});
            void'(issued.pop_back());
            m_fa = fa;
            m_fb = fb;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (model_valid) begin
            bit e_lu, e_br, e_st;
            e_lu = !reset && lu();
            e_br = !reset && branchTaken;
            e_st = e_lu && !e_br;
            check("pcWrite",    32'(pcWrite),    32'(!e_st));
            check("ifIdWrite",  32'(ifIdWrite),  32'(!e_st));
            check("ifIdFlush",  32'(ifIdFlush),  32'(e_br));
            check("idExFlush",  32'(idExFlush),  32'(e_lu || e_br));
            check("fwdA",       32'(fwdA),       32'(m_fa));
            check("fwdB",       32'(fwdB),       32'(m_fb));
            check("stallCount", 32'(stallCount), 32'(m_sc));
            check("flushCount", 32'(flushCount), 32'(m_fc));
            // A stall can never be followed directly by another stall.
            if (pcWrite === 1'b0) check("no_restall", 32'(prev_low), 32'd0);
            prev_low = (pcWrite === 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input int rs, input int rt, input bit urs, input bit urt,
                       input int dest, input bit rw, input bit mr, input bit br);
        @(posedge clock);
        #1;
        idRs        = RB'(rs);
        idRt        = RB'(rt);
        idUsesRs    = urs;
        idUsesRt    = urt;
        idDest      = RB'(dest);
        idRegWrite  = rw;
        idMemRead   = mr;
        branchTaken = br;
    endtask

    task automatic nop();
        put(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idRs = '0; idRt = '0; idDest = '0;
        idUsesRs = 1'b0; idUsesRt = 1'b0; idRegWrite = 1'b0; idMemRead = 1'b0;
        branchTaken = 1'b1;   // must be ignored while reset is high
        @(posedge clock); @(posedge clock); #1;
        check("rst_pcWrite",   32'(pcWrite),   32'd1);
        check("rst_ifIdFlush", 32'(ifIdFlush), 32'd0);
        check("rst_idExFlush", 32'(idExFlush), 32'd0);
        check("rst_fwdA",      32'(fwdA),      32'd0);
        check("rst_flushCnt",  32'(flushCount), 32'd0);
        branchTaken = 1'b0;
        reset = 1'b0;

        // EX-to-EX: add $3,$1,$2 ; sub $4,$3,$5
        put(1, 2, 1, 1, 3, 1, 0, 0);
        put(3, 5, 1, 1, 4, 1, 0, 0);
        #1 check("ex_ex_pcWrite", 32'(pcWrite), 32'd1);
        nop();
        check("ex_ex_fwdA", 32'(fwdA), 32'd2);
        check("ex_ex_fwdB", 32'(fwdB), 32'd0);

        // MEM-to-EX: add $3 ; and $10,$11,$12 ; or $6,$7,$3
        put(1, 2, 1, 1, 3, 1, 0, 0);
        put(11, 12, 1, 1, 10, 1, 0, 0);
        put(7, 3, 1, 1, 6, 1, 0, 0);
        nop();
        check("mem_ex_fwdB", 32'(fwdB), 32'd1);
        check("mem_ex_fwdA", 32'(fwdA), 32'd0);

        // Load-use: lw $8,0($1) ; add $9,$8,$8
        put(1, 0, 1, 0, 8, 1, 1, 0);
        put(8, 8, 1, 1, 9, 1, 0, 0);
        #1;
        check("lu_pcWrite",   32'(pcWrite),    32'd0);
        check("lu_ifIdWrite", 32'(ifIdWrite),  32'd0);
        check("lu_idExFlush", 32'(idExFlush),  32'd1);
        check("lu_stall0",    32'(stallCount), 32'd0);
        put(8, 8, 1, 1, 9, 1, 0, 0);   // held in ID
        #1;
        check("lu_resume",    32'(pcWrite),    32'd1);
        check("lu_stall1",    32'(stallCount), 32'd1);
        nop();
        check("lu_fwdA", 32'(fwdA), 32'd1);
        check("lu_fwdB", 32'(fwdB), 32'd1);

        // Register 0: add $0,$1,$2 ; add $4,$0,$0 ; then lw $0 ; use $0
        put(1, 2, 1, 1, 0, 1, 0, 0);
        put(0, 0, 1, 1, 4, 1, 0, 0);
        #1 check("r0_pcWrite", 32'(pcWrite), 32'd1);
        nop();
        check("r0_fwdA", 32'(fwdA), 32'd0);
        check("r0_fwdB", 32'(fwdB), 32'd0);
        put(1, 0, 1, 0, 0, 1, 1, 0);
        put(0, 0, 1, 1, 5, 1, 0, 0);
        #1 check("r0_lw_nostall", 32'(pcWrite), 32'd1);

        // Branch over load-use
        put(1, 0, 1, 0, 8, 1, 1, 0);
        put(8, 8, 1, 1, 9, 1, 0, 1);
        #1;
        check("br_pcWrite",   32'(pcWrite),   32'd1);
        check("br_ifIdWrite", 32'(ifIdWrite), 32'd1);
        check("br_ifIdFlush", 32'(ifIdFlush), 32'd1);
        check("br_idExFlush", 32'(idExFlush), 32'd1);
        nop();
        check("br_stallCnt", 32'(stallCount), 32'd1);
        check("br_flushCnt", 32'(flushCount), 32'd1);
        check("br_fwdA",     32'(fwdA),       32'd0);

        // Saturation: 15 more stalls and 16 more flushes on 4-bit counters
        for (int i = 0; i < 15; i++) begin
            put(1, 0, 1, 0, 8, 1, 1, 0);
            put(2, 8, 1, 1, 9, 1, 0, 0);
            put(2, 8, 1, 1, 9, 1, 0, 0);
        end
        check("sat_stall", 32'(stallCount), 32'(CMAX));
        for (int i = 0; i < 16; i++) put(0, 0, 0, 0, 0, 0, 0, 1);
        nop();
        check("sat_flush", 32'(flushCount), 32'(CMAX));

        // Reset asserted mid-stall
        put(1, 0, 1, 0, 8, 1, 1, 0);
        put(8, 0, 1, 0, 9, 1, 0, 0);
        #1 check("mid_stall", 32'(pcWrite), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_hz_pcWrite",   32'(pcWrite),   32'd1);
        check("rst_hz_idExFlush", 32'(idExFlush), 32'd0);
        @(posedge clock); #1;
        check("rst_stallCnt", 32'(stallCount), 32'd0);
        check("rst_flushCnt2", 32'(flushCount), 32'd0);
        check("rst_fwdA2",    32'(fwdA),       32'd0);
        check("rst_fwdB2",    32'(fwdB),       32'd0);
        reset = 1'b0;
        #1 check("post_rst_run", 32'(pcWrite), 32'd1);
        nop();
        nop();
        @(posedge clock); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
